// File: rtl/sparc_data_ram.sv
// rtl/sparc_data_ram.sv - big-endian byte-addressed data RAM with MFA/MFC handshake
// Optional alignment error reporting: SPARC_DATA_RAM_ALIGN_CHECK_EN
module sparc_data_ram #(
   parameter int ADDR_W  = 9,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mfa,
   input  logic              rw,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              mfc,
   output logic              busy
`ifdef SPARC_DATA_RAM_ALIGN_CHECK_EN
   ,
   output logic              mem_err
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_COMPLETE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic [1:0]        size_q, size_d;
   logic              sign_ext_q, sign_ext_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_in_q, data_in_d;
   logic [31:0]       data_out_q, data_out_d;
   logic              mfc_q, mfc_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [7:0]        rd_b0, rd_b1, rd_b2, rd_b3;
   logic [31:0]       ld_data;
   logic              misaligned;
   logic              access_ok;
   logic              do_access;
   logic              we;

   // Alignment is forced by clearing low address bits; offsets wrap at ADDR_W bits.
   always_comb begin
      a0 = addr_q;
      case (size_q)
         2'b00:   a0 = addr_q;
         2'b01:   a0 = {addr_q[ADDR_W-1:1], 1'b0};
         default: a0 = {addr_q[ADDR_W-1:2], 2'b00};
      endcase
      a1 = a0 + ADDR_W'(1);
      a2 = a0 + ADDR_W'(2);
      a3 = a0 + ADDR_W'(3);
   end

   assign rd_b0 = mem[a0];
   assign rd_b1 = mem[a1];
   assign rd_b2 = mem[a2];
   assign rd_b3 = mem[a3];

   assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                       (size_q[1] && (addr_q[1:0] != 2'b00));

`ifdef SPARC_DATA_RAM_ALIGN_CHECK_EN
   assign access_ok = ~misaligned;
`else
   assign access_ok = 1'b1;
`endif

   always_comb begin
      ld_data = {rd_b0, rd_b1, rd_b2, rd_b3};
      case (size_q)
         2'b00:   ld_data = {{24{sign_ext_q & rd_b0[7]}}, rd_b0};
         2'b01:   ld_data = {{16{sign_ext_q & rd_b0[7]}}, rd_b0, rd_b1};
         default: ld_data = {rd_b0, rd_b1, rd_b2, rd_b3};
      endcase
   end

   assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
   assign we        = do_access && !rw_q && access_ok;

   // Storage is deliberately not reset; an aborted access never reaches do_access.
   always_ff @(posedge clk) begin
      if (we) begin
         case (size_q)
            2'b00: begin
               mem[a0] <= data_in_q[7:0];
            end
            2'b01: begin
               mem[a0] <= data_in_q[15:8];
               mem[a1] <= data_in_q[7:0];
            end
            default: begin
               mem[a0] <= data_in_q[31:24];
               mem[a1] <= data_in_q[23:16];
               mem[a2] <= data_in_q[15:8];
               mem[a3] <= data_in_q[7:0];
            end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      size_d     = size_q;
      sign_ext_d = sign_ext_q;
      addr_d     = addr_q;
      data_in_d  = data_in_q;
      data_out_d = data_out_q;
      mfc_d      = mfc_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (mfa) begin
               rw_d       = rw;
               size_d     = size;
               sign_ext_d = sign_ext;
               addr_d     = addr;
               data_in_d  = data_in;
               cnt_d      = CNT_INIT;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_COMPLETE;
               mfc_d   = 1'b1;
               err_d   = !access_ok;
               if (rw_q && access_ok) begin
                  data_out_d = ld_data;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_COMPLETE: begin
            if (!mfa) begin
               state_d = ST_IDLE;
               mfc_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mfc_d   = 1'b0;
            err_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         rw_q       <= 1'b0;
         size_q     <= 2'b00;
         sign_ext_q <= 1'b0;
         addr_q     <= '0;
         data_in_q  <= 32'h0;
         data_out_q <= 32'h0;
         mfc_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         size_q     <= size_d;
         sign_ext_q <= sign_ext_d;
         addr_q     <= addr_d;
         data_in_q  <= data_in_d;
         data_out_q <= data_out_d;
         mfc_q      <= mfc_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign data_out = data_out_q;
   assign mfc      = mfc_q;
   assign busy     = busy_q;

`ifdef SPARC_DATA_RAM_ALIGN_CHECK_EN
   assign mem_err = err_q;
`else
   logic unused_err;
   assign unused_err = err_q ^ misaligned;
`endif

endmodule
